// File: rtl/fht_frame_sched.sv
// Frame sequencer around the FHT core: load one frame into RAM set A, start the FHT, then
// unload the result set through a 2-entry skid buffer. Define FHT_SCHED_TIMEOUT_EN for the run watchdog.
module fht_frame_sched #(
  parameter int N_BIT   = 10,
  parameter int A_BIT   = 8,
  parameter int D_BIT   = 16,
  parameter int TMO_BIT = 12
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic [D_BIT-1:0] iDATA,
  input  logic             iVALID,
  output logic             oREADY,
  output logic             oWE,
  output logic [1:0]       oWR_BANK,
  output logic [A_BIT-1:0] oWR_ADDR,
  output logic [D_BIT-1:0] oWR_DATA,
  output logic             oFHT_START,
  input  logic             iFHT_RDY,
  input  logic             iRESULT_SEL,
  output logic             oRD_SET,
  output logic [1:0]       oRD_BANK,
  output logic [A_BIT-1:0] oRD_ADDR,
  input  logic [D_BIT-1:0] iRD_DATA,
  output logic [D_BIT-1:0] oDATA,
  output logic             oVALID,
  output logic             oLAST,
  input  logic             iREADY,
  output logic             oBUSY,
  output logic             oFRAME_DONE,
  output logic             oERR
);
  typedef enum logic [1:0] {LOAD, START, RUN, UNLOAD} state_t;

  localparam logic [N_BIT-1:0] K_MAX = '1;
  localparam logic [N_BIT-1:0] K_ONE = 1;
  localparam logic [N_BIT:0]   R_ONE = 1;

  state_t           state_q;
  logic [N_BIT-1:0] k_q, o_q;
  logic [N_BIT:0]   r_q;
  logic             seen_low_q, inflight_q, rd_set_q;
  logic             we_q, start_q, done_q, err_q;
  logic [1:0]       wr_bank_q, rd_bank_q;
  logic [A_BIT-1:0] wr_addr_q, rd_addr_q;
  logic [D_BIT-1:0] wr_data_q;
  logic [1:0]       cnt_q, cnt_d;
  logic             wp_q, rp_q;
  logic [D_BIT-1:0] buf_q [2];
  logic             push, pop, issue;
  logic [2:0]       occ;

`ifdef FHT_SCHED_TIMEOUT_EN
  localparam logic [TMO_BIT-1:0] TMO_ONE  = 1;
  localparam logic [TMO_BIT-1:0] TMO_LAST = {{(TMO_BIT-1){1'b1}}, 1'b0};
  logic [TMO_BIT-1:0] tmo_q;
`else
  logic [TMO_BIT-1:0] tmo_unused;
  assign tmo_unused = '0;
`endif

  // A word leaving this cycle frees its slot, so the next read can issue now: keeps 1 word/cycle.
  assign push  = inflight_q;
  assign pop   = (cnt_q != 2'd0) && iREADY;
  assign occ   = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue = (state_q == UNLOAD) && !r_q[N_BIT] && (occ < 3'd2);
  assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      state_q    <= LOAD;
      k_q        <= '0;
      o_q        <= '0;
      r_q        <= '0;
      seen_low_q <= 1'b0;
      inflight_q <= 1'b0;
      rd_set_q   <= 1'b0;
      we_q       <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_bank_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_bank_q  <= '0;
      rd_addr_q  <= '0;
      cnt_q      <= '0;
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
`ifdef FHT_SCHED_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      we_q       <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      inflight_q <= issue;
      cnt_q      <= cnt_d;
      if (push) wp_q <= ~wp_q;
      if (pop) begin
        rp_q <= ~rp_q;
        o_q  <= o_q + K_ONE;
      end
      if (issue) begin
        rd_bank_q <= r_q[1:0];
        rd_addr_q <= r_q[N_BIT-1:2];
        r_q       <= r_q + R_ONE;
      end
      case (state_q)
        LOAD: if (iVALID) begin
          we_q      <= 1'b1;
          wr_data_q <= iDATA;
          wr_bank_q <= k_q[1:0];
          wr_addr_q <= k_q[N_BIT-1:2];
          k_q       <= k_q + K_ONE;
          if (k_q == K_MAX) state_q <= START;
        end
        START: begin
          start_q    <= 1'b1;
          seen_low_q <= 1'b0;
`ifdef FHT_SCHED_TIMEOUT_EN
          tmo_q      <= '0;
`endif
          state_q    <= RUN;
        end
        RUN: begin
          // Ready is only trusted once the controller has dropped it to acknowledge start.
          if (!iFHT_RDY) seen_low_q <= 1'b1;
          if (seen_low_q && iFHT_RDY) begin
            rd_set_q <= iRESULT_SEL;
            r_q      <= '0;
            o_q      <= '0;
            state_q  <= UNLOAD;
          end
`ifdef FHT_SCHED_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            tmo_q   <= tmo_q + TMO_ONE;
            err_q   <= 1'b1;
            k_q     <= '0;
            state_q <= LOAD;
          end else begin
            tmo_q <= tmo_q + TMO_ONE;
          end
`endif
        end
        UNLOAD: if (pop && (o_q == K_MAX)) begin
          done_q  <= 1'b1;
          state_q <= LOAD;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (push) buf_q[wp_q] <= iRD_DATA;
  end

  assign oREADY      = (state_q == LOAD);
  assign oBUSY       = (state_q != LOAD);
  assign oWE         = we_q;
  assign oWR_BANK    = wr_bank_q;
  assign oWR_ADDR    = wr_addr_q;
  assign oWR_DATA    = wr_data_q;
  assign oFHT_START  = start_q;
  assign oRD_SET     = rd_set_q;
  assign oRD_BANK    = rd_bank_q;
  assign oRD_ADDR    = rd_addr_q;
  assign oVALID      = (cnt_q != 2'd0);
  assign oDATA       = buf_q[rp_q];
  assign oLAST       = oVALID && (o_q == K_MAX);
  assign oFRAME_DONE = done_q;
`ifdef FHT_SCHED_TIMEOUT_EN
  assign oERR        = err_q;
`else
  assign oERR        = 1'b0;
`endif
endmodule
